// File: rtl/pcie_phy_rx.sv
// rtl/pcie_phy_rx.sv - 128b/130b receive datapath: block lock, lane merge, descramble
// Optional PCIE_RX_ERR_CNT_EN enables the saturating sync_err_cnt register.
module pcie_phy_rx #(
  parameter int          DATA_WIDTH = 128,
  parameter int          LOCK_CNT   = 4,
  parameter int          UNLOCK_CNT = 2,
  parameter logic [22:0] SCR_SEED   = 23'h1DBFBC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           lane0,
  input  logic [31:0]           lane1,
  input  logic [31:0]           lane2,
  input  logic [31:0]           lane3,
  input  logic [1:0]            sync_hdr,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  block_type,
  output logic                  locked,
  output logic [7:0]            sync_err_cnt
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] EIEOS = {8{16'hFF00}};

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt, cnt_inc;
  logic                  hdr_ok, hdr_os, fwd, lock_lost;

  logic                  s1_fwd, s1_os, s1_reload;
  logic [DATA_WIDTH-1:0] s1_data;

  logic [22:0]           lfsr, lfsr_adv;
  logic [DATA_WIDTH-1:0] ks;

  assign hdr_ok  = (sync_hdr == 2'b10) || (sync_hdr == 2'b01);
  assign hdr_os  = (sync_hdr == 2'b01);
  assign cnt_inc = cnt + 4'd1;
  assign locked  = (state == ST_LOCKED);
  // Forwarding is decided on the pre-update state, so the lock-completing block is dropped.
  assign fwd     = in_valid && hdr_ok && (state == ST_LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_UNLOCKED;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lock_lost = 1'b0;
    if (in_valid) begin
      unique case (state)
        ST_UNLOCKED, ST_LOCKING: begin
          if (!hdr_ok) begin
            state_nxt = ST_UNLOCKED;
            cnt_nxt   = 4'd0;
          end else if (cnt_inc == 4'(LOCK_CNT)) begin
            state_nxt = ST_LOCKED;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = ST_LOCKING;
            cnt_nxt   = cnt_inc;
          end
        end
        ST_LOCKED: begin
          if (hdr_ok) begin
            cnt_nxt = 4'd0;
          end else if (cnt_inc == 4'(UNLOCK_CNT)) begin
            state_nxt = ST_UNLOCKED;
            cnt_nxt   = 4'd0;
            lock_lost = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = ST_UNLOCKED;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

`ifdef PCIE_RX_ERR_CNT_EN
  logic       err_inc;
  logic [7:0] err_cnt;

  assign err_inc = in_valid && !hdr_ok && (state == ST_LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= 8'd0;
    end else if (err_inc && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign sync_err_cnt = err_cnt;
`else
  assign sync_err_cnt = 8'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_fwd    <= 1'b0;
      s1_os     <= 1'b0;
      s1_reload <= 1'b0;
      s1_data   <= '0;
    end else begin
      s1_fwd    <= fwd;
      s1_os     <= hdr_os;
      s1_reload <= lock_lost;
      if (in_valid) begin
        s1_data <= {lane3, lane2, lane1, lane0};
      end
    end
  end

  // Keystream bit k is l[22] before step k; lfsr_adv is the state after the full block.
  always_comb begin
    lfsr_adv = lfsr;
    ks       = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      ks[k]    = lfsr_adv[22];
      lfsr_adv = {lfsr_adv[21:0],
                  lfsr_adv[22] ^ lfsr_adv[20] ^ lfsr_adv[15] ^
                  lfsr_adv[7]  ^ lfsr_adv[4]  ^ lfsr_adv[1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      block_type <= 1'b0;
      lfsr       <= SCR_SEED;
    end else begin
      data_valid <= s1_fwd;
      if (s1_fwd) begin
        block_type <= s1_os;
        if (s1_os) begin
          data_out <= s1_data;
          if (s1_data == EIEOS) begin
            lfsr <= SCR_SEED;
          end
        end else begin
          data_out <= s1_data ^ ks;
          lfsr     <= lfsr_adv;
        end
      end
      // A lock-loss block is never forwarded, so this cannot collide with an advance.
      if (s1_reload) begin
        lfsr <= SCR_SEED;
      end
    end
  end

endmodule
